// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin A2D conversion scheduler for the six slide pots.
// Issues one conversion at a time to the SPI A2D master, keeps the latest
// 12-bit result per pot, and starts a fresh scan SCAN_GAP clocks after the
// previous one ends.
module pot_scan_ctrl #(
  parameter int SCAN_GAP = 4096,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] LP,
  output logic [11:0] B1,
  output logic [11:0] B2,
  output logic [11:0] B3,
  output logic [11:0] HP,
  output logic [11:0] VOL,
  output logic        scan_done,
  output logic        timeout_err
);

  localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(SCAN_GAP - 1);
  localparam logic [TW-1:0] TO_RELOAD  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX   = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    STORE
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  to_q, to_d;
  logic           strt_q, strt_d;
  logic [2:0]     chnnl_q, chnnl_d;
  logic           done_q, done_d;
  logic           terr_q, terr_d;
  logic [11:0]    pot_q [6];
  logic [11:0]    pot_d [6];

  // Slot order on the A2D mux: LP, B1, B2, B3, HP, VOL.
  function automatic logic [2:0] slot_chnnl(input logic [2:0] idx);
    logic [2:0] ch;
    case (idx)
      3'd0:    ch = 3'd1;
      3'd1:    ch = 3'd0;
      3'd2:    ch = 3'd4;
      3'd3:    ch = 3'd2;
      3'd4:    ch = 3'd3;
      3'd5:    ch = 3'd7;
      default: ch = 3'd1;
    endcase
    return ch;
  endfunction

  // Next-state, counter and result-capture logic for the scan sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    to_d    = to_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    pot_d   = pot_q;

    case (state_q)
      IDLE: begin
        if (!en) begin
          gap_d = GAP_RELOAD;
        end else if (gap_q == '0) begin
          state_d = START;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      START: begin
        to_d    = to_q - 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (cnv_cmplt) begin
          for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) pot_d[i] = res;
          end
          state_d = STORE;
        end else if (to_q == '0) begin
          terr_d  = 1'b1;
          state_d = STORE;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      STORE: begin
        if (idx_q == LAST_IDX || !en) begin
          done_d  = (idx_q == LAST_IDX);
          idx_d   = 3'd0;
          gap_d   = GAP_RELOAD;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase

    // The timeout counter holds TIMEOUT-1 during the strt_cnv cycle, so that
    // cycle is the first of the TIMEOUT clocks allowed for the conversion.
    if (state_d == START) to_d = TO_RELOAD;

    strt_d  = (state_d == START);
    chnnl_d = slot_chnnl(idx_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      gap_q   <= GAP_RELOAD;
      to_q    <= TO_RELOAD;
      strt_q  <= 1'b0;
      chnnl_q <= 3'd1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      // NOTE: the pot registers are architectural outputs that must read zero
      // after reset, so this small storage array is reset like any flop.
      pot_q   <= '{default: '0};
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      strt_q  <= strt_d;
      chnnl_q <= chnnl_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      pot_q   <= pot_d;
    end
  end

  assign strt_cnv    = strt_q;
  assign chnnl       = chnnl_q;
  assign scan_done   = done_q;
  assign timeout_err = terr_q;
  assign LP          = pot_q[0];
  assign B1          = pot_q[1];
  assign B2          = pot_q[2];
  assign B3          = pot_q[3];
  assign HP          = pot_q[4];
  assign VOL         = pot_q[5];

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Self-checking bench for pot_scan_ctrl with a behavioural A2D master model.
module tb_pot_scan_ctrl;

  localparam int G   = 16;  // SCAN_GAP
  localparam int T   = 8;   // TIMEOUT
  localparam int LAT = 4;   // A2D model latency, strt_cnv to cnv_cmplt

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        strt_cnv, cnv_cmplt, scan_done, timeout_err;
  logic [2:0]  chnnl;
  logic [11:0] res, LP, B1, B2, B3, HP, VOL;

  pot_scan_ctrl #(.SCAN_GAP(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res),
    .LP(LP), .B1(B1), .B2(B2), .B3(B3), .HP(HP), .VOL(VOL),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Pot voltages as seen by the A2D, indexed by A2D channel.
  logic [11:0] pot_val [8];
  logic        hold_en;
  logic [2:0]  hold_ch;
  int          spur_idle_req, spur_start_req;
  int          spur_idle_ack, spur_start_ack;
  int          pend;
  logic [2:0]  pend_ch;

  int cyc, strt_total, done_cnt;
  int n_tests, n_fail;
  int ch_q[$];
  int t_q[$];

  int slot_ch [6] = '{1, 0, 4, 2, 3, 7};

  typedef struct packed {
    logic [5:0][11:0] val;
    logic             hold;
    logic [2:0]       hold_c;
    logic [5:0][11:0] exp_pot;
    logic             exp_terr;
  } vec_t;

  vec_t vecs [4];

  function automatic vec_t mk(input logic [11:0] a0, a1, a2, a3, a4, a5,
                              input logic h, input logic [2:0] hc,
                              input logic [11:0] e0, e1, e2, e3, e4, e5,
                              input logic et);
    vec_t v;
    v.val[0] = a0; v.val[1] = a1; v.val[2] = a2;
    v.val[3] = a3; v.val[4] = a4; v.val[5] = a5;
    v.hold = h; v.hold_c = hc;
    v.exp_pot[0] = e0; v.exp_pot[1] = e1; v.exp_pot[2] = e2;
    v.exp_pot[3] = e3; v.exp_pot[4] = e4; v.exp_pot[5] = e5;
    v.exp_terr = et;
    return v;
  endfunction

  function automatic logic [11:0] get_pot(input int slot);
    case (slot)
      0: return LP;
      1: return B1;
      2: return B2;
      3: return B3;
      4: return HP;
      default: return VOL;
    endcase
  endfunction

  // Cycle counter: number of rising edges seen.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor on the falling edge: log every strt_cnv and count scan_done.
  initial begin
    strt_total = 0;
    done_cnt   = 0;
    forever begin
      @(negedge clk);
      if (strt_cnv) begin
        ch_q.push_back(int'(chnnl));
        t_q.push_back(cyc);
        strt_total++;
      end
      if (scan_done) done_cnt++;
    end
  end

  // A2D master model: answers each strt_cnv LAT cycles later unless the
  // channel is withheld; can inject stray cnv_cmplt pulses on request.
  initial begin
    cnv_cmplt = 1'b0;
    res = 12'h000;
    pend = 0;
    pend_ch = 3'd0;
    spur_idle_ack = 0;
    spur_start_ack = 0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cnv_cmplt = 1'b1;
          res = pot_val[pend_ch];
        end
      end
      if (spur_idle_req != spur_idle_ack) begin
        cnv_cmplt = 1'b1;
        res = 12'hBAD;
        spur_idle_ack = spur_idle_req;
      end else if (spur_start_req != spur_start_ack && strt_cnv) begin
        cnv_cmplt = 1'b1;
        res = 12'hBAD;
        spur_start_ack = spur_start_req;
      end
      if (strt_cnv && !(hold_en && chnnl == hold_ch)) begin
        pend = LAT;
        pend_ch = chnnl;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_strt(input int budget);
    int s0, k;
    s0 = strt_total;
    k = 0;
    while (strt_total == s0 && k < budget) begin
      tick(1);
      k++;
    end
    check("strt_cnv_arrived", (strt_total != s0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(1);
      k++;
    end
    check("scan_done_arrived", (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_slot_vals(input logic [5:0][11:0] v);
    for (int i = 0; i < 6; i++) pot_val[slot_ch[i]] = v[i];
  endtask

  task automatic check_order(input int base, input string tag);
    check({tag, "_strt_count"}, 32'(ch_q.size() - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < ch_q.size())
        check({tag, "_chnnl_order"}, 32'(ch_q[base + k]), 32'(slot_ch[k]));
    end
  endtask

  task automatic check_pots(input logic [5:0][11:0] e, input string tag);
    for (int i = 0; i < 6; i++) check({tag, "_pot"}, 32'(get_pot(i)), 32'(e[i]));
  endtask

  // Hard stop in case something wedges beyond the per-wait budgets.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, s0, d0, k;
    logic [5:0][11:0] e;
    n_tests = 0;
    n_fail  = 0;
    hold_en = 1'b0;
    hold_ch = 3'd0;
    spur_idle_req = 0;
    spur_start_req = 0;
    for (int i = 0; i < 8; i++) pot_val[i] = 12'h000;

    vecs[0] = mk(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h112, 1'b0, 3'd0,
                 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h112, 1'b0);
    vecs[1] = mk(12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'hFFF, 1'b0, 3'd0,
                 12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'hFFF, 1'b0);
    vecs[2] = mk(12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 1'b1, 3'd4,
                 12'h111, 12'h222, 12'h789, 12'h444, 12'h555, 12'h666, 1'b1);
    vecs[3] = mk(12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 1'b0, 3'd0,
                 12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 1'b1);

    // Reset values.
    tick(2);
    check("rst_strt_cnv", 32'(strt_cnv), 32'd0);
    check("rst_chnnl", 32'(chnnl), 32'd1);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_pots('0, "rst");
    rst_n = 1'b1;
    tick(5);
    check("idle_no_strt_while_en_low", 32'(strt_total), 32'd0);

    // First scan: LP=800, VOL=112, first strt_cnv G clocks after en.
    pot_val[1] = 12'h800;
    pot_val[7] = 12'h112;
    base = ch_q.size();
    c0 = cyc;
    en = 1'b1;
    wait_strt(G + 5);
    if (ch_q.size() > base) check("first_strt_delay", 32'(t_q[base] - c0), 32'(G));
    wait_done(300);
    check_order(base, "scan1");
    e = '0;
    e[0] = 12'h800;
    e[5] = 12'h112;
    check_pots(e, "scan1");
    tick(3);
    check("scan1_single_done", 32'(done_cnt), 32'd1);

    // Table-driven scans.
    for (int v = 0; v < 4; v++) begin
      set_slot_vals(vecs[v].val);
      hold_en = vecs[v].hold;
      hold_ch = vecs[v].hold_c;
      base = ch_q.size();
      wait_done(400);
      check_order(base, $sformatf("vec%0d", v));
      check_pots(vecs[v].exp_pot, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_timeout_err", v), 32'(timeout_err), 32'(vecs[v].exp_terr));
      if (vecs[v].hold) begin
        for (int s = 0; s < 5; s++) begin
          if (slot_ch[s] == int'(vecs[v].hold_c) && base + s + 1 < t_q.size())
            check($sformatf("vec%0d_timeout_gap", v),
                  32'(t_q[base + s + 1] - t_q[base + s]), 32'(T + 1));
        end
      end
    end
    hold_en = 1'b0;

    // Stray completions in IDLE and in START change nothing.
    e = vecs[3].exp_pot;
    spur_idle_req++;
    tick(4);
    check_pots(e, "spur_idle");
    for (int i = 0; i < 6; i++) e[i] = 12'(16 * (i + 1));
    set_slot_vals(e);
    spur_start_req++;
    base = ch_q.size();
    wait_done(400);
    check_order(base, "spur_start");
    check_pots(e, "spur_start");

    // Drop en while waiting on B1: B1 stored, then park without scan_done.
    pot_val[1] = 12'h0A0;
    pot_val[0] = 12'h5A5;
    wait_strt(G + 5);
    wait_strt(40);
    if (ch_q.size() > 0) check("drop_on_b1_chnnl", 32'(ch_q[ch_q.size() - 1]), 32'd0);
    tick(1);
    en = 1'b0;
    s0 = strt_total;
    d0 = done_cnt;
    tick(40);
    e[0] = 12'h0A0;
    e[1] = 12'h5A5;
    check_pots(e, "drop_en");
    check("drop_en_no_strt", 32'(strt_total), 32'(s0));
    check("drop_en_no_done", 32'(done_cnt), 32'(d0));
    base = ch_q.size();
    c0 = cyc;
    en = 1'b1;
    wait_strt(G + 5);
    if (ch_q.size() > base) begin
      check("reen_first_chnnl", 32'(ch_q[base]), 32'd1);
      check("reen_strt_delay", 32'(t_q[base] - c0), 32'(G));
    end
    wait_done(400);
    check_order(base, "reen");

    // Async reset while in WAIT; the late completion must be ignored.
    wait_strt(G + 5);
    tick(1);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_pots('0, "mid_rst");
    check("mid_rst_strt_cnv", 32'(strt_cnv), 32'd0);
    check("mid_rst_chnnl", 32'(chnnl), 32'd1);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    tick(1);
    rst_n = 1'b1;
    s0 = strt_total;
    d0 = done_cnt;
    k = 0;
    tick(10);
    check_pots('0, "post_rst");
    check("post_rst_no_strt", 32'(strt_total), 32'(s0));
    check("post_rst_no_done", 32'(done_cnt), 32'(d0 + k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
